sic1_loader: RTL

//  Host-side program loader for the SIC1 core. Accepts a length-prefixed byte stream over a

---
 rtl/sic1_loader.sv | 88 ++++++++
 1 files changed

// File: rtl/sic1_loader.sv
// Host-side program loader: length-prefixed byte stream -> SIC1 byte-write port, CPU held while busy.
// One data byte per two cycles (DATA accept, WRITE issue); source stalls hold state with busy=1.
module sic1_loader #(
  parameter logic [7:0] ADDR_MAX  = 8'd252,
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [5:0] mem_ra_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_addr,
  output logic [7:0] mem_wr_byte,
  output logic       busy,
  output logic       cpu_hold,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] r_state;
  logic [7:0] r_addr;
  logic [7:0] r_remaining;
  logic [7:0] r_data_q;

  logic w_xfer;
  logic w_in_write;

  assign in_ready   = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_xfer     = in_valid && in_ready;
  assign w_in_write = (r_state == S_WRITE);

  assign busy        = (r_state != S_IDLE);
  assign cpu_hold    = busy;
  assign done        = (r_state == S_DONE);
  assign mem_ra_addr = busy ? r_addr[7:2] : 6'd0;
  // Gated by rst so a write cycle interrupted by reset never reaches memory.
  assign mem_wr_en   = w_in_write && (r_addr <= ADDR_MAX) && !rst;
  assign mem_wr_addr = w_in_write ? r_addr : 8'd0;
  assign mem_wr_byte = w_in_write ? r_data_q : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= BASE_ADDR;
      r_remaining <= 8'd0;
      r_data_q    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_LEN;
        end
        S_LEN: begin
          if (w_xfer) begin
            r_remaining <= in_data;
            r_addr      <= BASE_ADDR;
            r_state     <= (in_data == 8'd0) ? S_DONE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_data_q <= in_data;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 8'd1;
          r_remaining <= r_remaining - 8'd1;
          r_state     <= (r_remaining == 8'd1) ? S_DONE : S_DATA;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
